btn_conditioner: RTL



---
 rtl/controller_pkg.sv | 32 +++
 rtl/btn_channel.sv | 153 +++++++++++++++
 rtl/btn_conditioner.sv | 70 +++++++
 3 files changed

// File: rtl/controller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg
// Shared definitions for the controller board input logic:
//   - auto-repeat FSM state encoding (IDLE=0, HOLD=1, REPEAT=2)
//   - default timing constants derived from the 25 MHz system clock
//   - small elaboration-time helpers for counter sizing
// ---------------------------------------------------------------------------
package controller_pkg;

    localparam int CLK_HZ = 25_000_000;

    // 10 ms debounce window, 500 ms initial hold, 100 ms repeat period.
    localparam int DEF_STABLE_CYCLES = CLK_HZ / 100;
    localparam int DEF_HOLD_CYCLES   = CLK_HZ / 2;
    localparam int DEF_REPEAT_CYCLES = CLK_HZ / 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rp_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One push-button channel: two-flop synchroniser, counter debounce,
// press/release strobes and a menu-style auto-repeat FSM.
//
// Ports:
//   clk_25mhz    in   system clock
//   reset        in   synchronous active-high reset
//   i_btn        in   raw asynchronous button level (1 = pressed)
//   o_level      out  debounced level (registered)
//   o_press      out  one-cycle strobe on accepted 0->1 (registered)
//   o_release    out  one-cycle strobe on accepted 1->0 (registered)
//   o_repeat     out  one-cycle auto-repeat tick while held (registered)
//   o_press_evt  out  next-cycle value of o_press, so the parent can
//                     register an aggregate strobe coincident with o_press
// ---------------------------------------------------------------------------
module btn_channel
    import controller_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk_25mhz,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_press_evt
);

    localparam int DB_W = cnt_width(STABLE_CYCLES);
    localparam int RP_W = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(STABLE_CYCLES - 1);
    localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
    localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES - 1);

    logic            r_q1;
    logic            r_q2;
    logic            r_level;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    logic [RP_W-1:0] r_rp_cnt;
    rp_state_e       r_state;

    logic            w_differ;
    logic            w_accept;
    logic            w_press_evt;
    logic            w_rel_evt;
    rp_state_e       w_state_next;
    logic [RP_W-1:0] w_rp_cnt_next;
    logic            w_repeat_next;

    // A level change is accepted on the edge where the synchronised input
    // has disagreed with the debounced level for STABLE_CYCLES edges in a row.
    assign w_differ    = (r_q2 != r_level);
    assign w_accept    = w_differ && (r_db_cnt == DB_LAST);
    assign w_press_evt = w_accept &&  r_q2;
    assign w_rel_evt   = w_accept && !r_q2;

    // Synchroniser, debounce and registered strobes.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_q1      <= 1'b0;
            r_q2      <= 1'b0;
            r_level   <= 1'b0;
            r_db_cnt  <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_rp_cnt  <= '0;
        end else begin
            r_q1 <= i_btn;
            r_q2 <= r_q1;
            if (!w_differ) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_level  <= r_q2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            r_press   <= w_press_evt;
            r_release <= w_rel_evt;
            r_repeat  <= w_repeat_next;
            r_rp_cnt  <= w_rp_cnt_next;
        end
    end

    // Auto-repeat FSM state register.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Auto-repeat next state. Release has priority over a coinciding count
    // match so that no tick is emitted on the release edge.
    always_comb begin
        w_state_next  = r_state;
        w_rp_cnt_next = r_rp_cnt;
        w_repeat_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press_evt) begin
                    w_state_next  = ST_HOLD;
                    w_rp_cnt_next = '0;
                end
            end
            ST_HOLD: begin
                if (w_rel_evt) begin
                    w_state_next  = ST_IDLE;
                    w_rp_cnt_next = '0;
                end else if (r_rp_cnt == HOLD_LAST) begin
                    w_state_next  = ST_REPEAT;
                    w_rp_cnt_next = '0;
                    w_repeat_next = 1'b1;
                end else begin
                    w_rp_cnt_next = r_rp_cnt + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (w_rel_evt) begin
                    w_state_next  = ST_IDLE;
                    w_rp_cnt_next = '0;
                end else if (r_rp_cnt == REP_LAST) begin
                    w_rp_cnt_next = '0;
                    w_repeat_next = 1'b1;
                end else begin
                    w_rp_cnt_next = r_rp_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_rp_cnt_next = '0;
            end
        endcase
    end

    assign o_level     = r_level;
    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_repeat    = r_repeat;
    assign o_press_evt = w_press_evt;

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Input-conditioning stage for the controller push buttons. Each of the
// WIDTH channels is synchronised, debounced and given press/release strobes
// and auto-repeat ticks; channels are fully independent.
//
// Ports:
//   clk_25mhz    in   system clock (only clock)
//   reset        in   synchronous active-high reset
//   btn          in   [WIDTH] raw button levels, 1 = pressed
//   btn_level    out  [WIDTH] debounced level
//   btn_press    out  [WIDTH] one-cycle strobe on accepted 0->1
//   btn_release  out  [WIDTH] one-cycle strobe on accepted 1->0
//   btn_repeat   out  [WIDTH] one-cycle auto-repeat tick while held
//   any_press    out  OR of btn_press, registered, coincident with it
// ---------------------------------------------------------------------------
module btn_conditioner
    import controller_pkg::*;
#(
    parameter int WIDTH         = 7,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic             clk_25mhz,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] btn_repeat,
    output logic             any_press
);

    logic [WIDTH-1:0] w_press_evt;
    logic             r_any_press;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gen_ch
            btn_channel #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_ch (
                .clk_25mhz   (clk_25mhz),
                .reset       (reset),
                .i_btn       (btn[gi]),
                .o_level     (btn_level[gi]),
                .o_press     (btn_press[gi]),
                .o_release   (btn_release[gi]),
                .o_repeat    (btn_repeat[gi]),
                .o_press_evt (w_press_evt[gi])
            );
        end
    endgenerate

    // Registering the OR of the pre-register press events keeps any_press a
    // flop output while lining it up with the per-channel strobes.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_evt;
        end
    end

    assign any_press = r_any_press;

endmodule
